// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
// Multi-cycle controller for the MIPS-subset CPU. Each instruction is
// sequenced through FETCH/DECODE/EXEC/MEM/WB. The controller waits on memory
// handshakes and holds in a stall state while the fixed-latency multiply unit
// runs.
//
// Parameters
//   MEM_HS  : 1 = FETCH/MEM wait for mem_ready, 0 = single-cycle memory
//   HAS_MDU : 1 = mult/mflo are legal, 0 = both decode as illegal
//   MDU_LAT : cycles spent in the MDU state for mult (>= 1)
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   opcode, funct     : IR[31:26], IR[5:0]; valid from DECODE onward
//   zero              : ALU equality result, used by beq in EXEC
//   mem_ready         : memory completes the current request this cycle
//   mem_req, ir_we,
//   pc_we, mdu_start  : memory request, IR load, PC write, MDU launch
//   EXT_op, ALU_op,
//   ALU_src           : immediate-extension, ALU operation, ALU B source
//   PC_op             : next-PC select
//   DM_WE, GRF_WE     : data memory / register file write enables
//   GRF_addr, GRF_data: register file destination / write-data selects
//   state             : current FSM state code
//   illegal           : sticky flag, set by any undecodable instruction
// -----------------------------------------------------------------------------
module mc_control #(
    parameter bit MEM_HS  = 1'b1,
    parameter bit HAS_MDU = 1'b1,
    parameter int MDU_LAT = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic       mdu_start,
    output logic [1:0] EXT_op,
    output logic [1:0] ALU_op,
    output logic [1:0] PC_op,
    output logic       DM_WE,
    output logic       GRF_WE,
    output logic [1:0] GRF_addr,
    output logic [1:0] GRF_data,
    output logic       ALU_src,
    output logic [2:0] state,
    output logic       illegal
);

    localparam int CW = $clog2(MDU_LAT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_MDU    = 3'b101
    } state_e;

    typedef enum logic [3:0] {
        I_ADD, I_SUB, I_JR, I_MULT, I_MFLO, I_NOP,
        I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_ILL
    } instr_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d;

    instr_e     instr_s;
    logic       mem_done_s;
    logic       mem_req_s, ir_we_s, pc_we_s, mdu_start_s, dm_we_s, grf_we_s;
    logic       alu_src_s;
    logic [1:0] ext_op_s, alu_op_s, pc_op_s, grf_addr_s, grf_data_s;

    // Instruction decode from the IR fields.
    always_comb begin
        instr_s = I_ILL;
        if (opcode == 6'b000000) begin
            case (funct)
                6'b100000: instr_s = I_ADD;
                6'b100010: instr_s = I_SUB;
                6'b001000: instr_s = I_JR;
                6'b011000: instr_s = HAS_MDU ? I_MULT : I_ILL;
                6'b010010: instr_s = HAS_MDU ? I_MFLO : I_ILL;
                6'b000000: instr_s = I_NOP;
                default:   instr_s = I_ILL;
            endcase
        end else begin
            case (opcode)
                6'b001101: instr_s = I_ORI;
                6'b100011: instr_s = I_LW;
                6'b101011: instr_s = I_SW;
                6'b000100: instr_s = I_BEQ;
                6'b001111: instr_s = I_LUI;
                6'b000011: instr_s = I_JAL;
                default:   instr_s = I_ILL;
            endcase
        end
    end

    // With MEM_HS=0 the memory always completes in one cycle.
    assign mem_done_s = MEM_HS ? mem_ready : 1'b1;

    // Next-state logic and per-state control outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        mem_req_s   = 1'b0;
        ir_we_s     = 1'b0;
        pc_we_s     = 1'b0;
        mdu_start_s = 1'b0;
        dm_we_s     = 1'b0;
        grf_we_s    = 1'b0;
        pc_op_s     = 2'b00;
        grf_addr_s  = 2'b00;
        grf_data_s  = 2'b00;
        alu_src_s   = 1'b0;
        ext_op_s    = 2'b00;
        alu_op_s    = 2'b00;

        // ALU selects are held through EXEC, MEM and WB.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (instr_s)
                I_SUB:      alu_op_s = 2'b01;
                I_BEQ:      alu_op_s = 2'b01;
                I_ORI:      begin alu_src_s = 1'b1; alu_op_s = 2'b10; end
                I_LW, I_SW: begin alu_src_s = 1'b1; ext_op_s = 2'b01; end
                I_LUI:      begin alu_src_s = 1'b1; ext_op_s = 2'b10; alu_op_s = 2'b10; end
                default:    alu_op_s = 2'b00;
            endcase
        end else begin
            alu_op_s = 2'b00;
        end

        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_done_s) begin
                    ir_we_s = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (instr_s)
                    I_JAL: begin
                        grf_we_s   = 1'b1;
                        grf_addr_s = 2'b10;
                        grf_data_s = 2'b10;
                        pc_we_s    = 1'b1;
                        pc_op_s    = 2'b10;
                        state_d    = S_FETCH;
                    end
                    I_JR: begin
                        pc_we_s = 1'b1;
                        pc_op_s = 2'b11;
                        state_d = S_FETCH;
                    end
                    I_NOP: begin
                        pc_we_s = 1'b1;
                        state_d = S_FETCH;
                    end
                    I_MULT: begin
                        mdu_start_s = 1'b1;
                        cnt_d       = CW'(MDU_LAT - 1);
                        state_d     = S_MDU;
                    end
                    I_MFLO:  state_d = S_WB;
                    I_ILL: begin
                        illegal_d = 1'b1;
                        pc_we_s   = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (instr_s == I_BEQ) begin
                    pc_we_s = 1'b1;
                    pc_op_s = zero ? 2'b01 : 2'b00;
                    state_d = S_FETCH;
                end else if (instr_s == I_LW || instr_s == I_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_s = 1'b1;
                if (instr_s == I_SW) begin
                    dm_we_s = mem_done_s;
                    pc_we_s = mem_done_s;
                    state_d = mem_done_s ? S_FETCH : S_MEM;
                end else begin
                    state_d = mem_done_s ? S_WB : S_MEM;
                end
            end
            S_WB: begin
                grf_we_s = 1'b1;
                pc_we_s  = 1'b1;
                state_d  = S_FETCH;
                case (instr_s)
                    I_ADD, I_SUB: grf_addr_s = 2'b01;
                    I_LW:         grf_data_s = 2'b01;
                    I_MFLO:       begin grf_addr_s = 2'b01; grf_data_s = 2'b11; end
                    default:      grf_addr_s = 2'b00;
                endcase
            end
            S_MDU: begin
                if (cnt_q == {CW{1'b0}}) begin
                    pc_we_s = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State, MDU counter and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= {CW{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes must react to mem_ready within the cycle, so they are decoded
    // from the state register; they are forced low while reset is asserted.
    assign mem_req   = mem_req_s & rst_n;
    assign ir_we     = ir_we_s & rst_n;
    assign pc_we     = pc_we_s & rst_n;
    assign mdu_start = mdu_start_s & rst_n;
    assign DM_WE     = dm_we_s & rst_n;
    assign GRF_WE    = grf_we_s & rst_n;
    assign PC_op     = pc_op_s;
    assign GRF_addr  = grf_addr_s;
    assign GRF_data  = grf_data_s;
    assign ALU_src   = alu_src_s;
    assign EXT_op    = ext_op_s;
    assign ALU_op    = alu_op_s;
    assign state     = state_q;
    assign illegal   = illegal_q;

endmodule
